seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_pkg.sv | 44 ++++
 rtl/seg7_glyph_decode.sv | 40 ++++
 rtl/seg_scan_decoder.sv | 239 +++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder: FSM state
// encoding, SEG bus bit positions and the 16 active-low hex glyphs.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } scan_state_e;

    localparam int SEG_CA = 0;
    localparam int SEG_CB = 1;
    localparam int SEG_CC = 2;
    localparam int SEG_CD = 3;
    localparam int SEG_CE = 4;
    localparam int SEG_CF = 5;
    localparam int SEG_CG = 6;
    localparam int SEG_DP = 7;

    // Active-low glyphs on SEG[6:0] (bit 0 = segment a ... bit 6 = segment g)
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    // True when exactly one bit of v is set
    function automatic logic onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational lookup of an active-low seven-segment pattern to a hex
// nibble. Patterns that are not one of the 16 hex glyphs flag invalid
// and return nibble 0.
module seg7_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       invalid
);

    // Glyph table lookup
    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b0;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: begin
                nibble  = 4'h0;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed seven-segment display bus (SEG/AN) and rebuilds the
// displayed hex value. A digit is sampled once its anode has been stable
// long enough; a frame is published only when every digit was captured
// with a legal glyph. Define SEG_SCAN_DP_EN to also capture decimal points.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            SEG,
    input  logic [7:0]            AN,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   dp,
    output logic                  frame_valid,
    output logic                  glyph_err,
    output logic                  an_err
);

    localparam logic [2:0]          LAST_IDX     = 3'(N_DIGITS - 1);
    localparam logic [7:0]          SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] ALL_CAPTURED = {N_DIGITS{1'b1}};
    localparam logic [N_DIGITS-1:0] NONE_CAPTURED = {N_DIGITS{1'b0}};

    scan_state_e           state_r, state_nxt_s;
    logic [7:0]            cnt_r, cnt_nxt_s;
    logic [7:0]            an_r;
    logic                  an_bad_prev_r;
    logic [7:0]            an_low_s;
    logic [2:0]            an_idx_s;
    logic                  an_valid_s, an_none_s, an_bad_s, an_chg_s;
    logic                  cap_en_s;
    logic [N_DIGITS-1:0]   cap_mask_s;
    logic [3:0]            glyph_nib_s;
    logic                  glyph_bad_s;
    logic [3:0]            shadow_r [N_DIGITS];
    logic [4*N_DIGITS-1:0] shadow_flat_s;
    logic [N_DIGITS-1:0]   captured_r;
    logic                  frame_chk_r;
    logic                  frame_gerr_r;
    logic                  frame_good_s;
    logic [4*N_DIGITS-1:0] digits_r;
    logic                  frame_valid_r;
    logic                  glyph_err_r;
    logic                  an_err_r;

    seg7_glyph_decode u_glyph (
        .seg     (SEG[SEG_CG:SEG_CA]),
        .nibble  (glyph_nib_s),
        .invalid (glyph_bad_s)
    );

    assign an_low_s     = ~AN;
    assign an_none_s    = (an_low_s == 8'h00);
    assign an_valid_s   = onehot8(an_low_s) && (an_idx_s <= LAST_IDX);
    assign an_bad_s     = !an_none_s && !an_valid_s;
    assign an_chg_s     = (AN != an_r);
    assign frame_good_s = (captured_r == ALL_CAPTURED) && !frame_gerr_r;

    // Encode the low anode bit into a digit index and a capture mask
    always_comb begin
        an_idx_s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low_s[i]) begin
                an_idx_s = 3'(i);
            end else begin
                an_idx_s = an_idx_s;
            end
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            cap_mask_s[i] = (an_idx_s == 3'(i));
        end
    end

    // Flatten the shadow nibbles into the output bus layout
    always_comb begin
        shadow_flat_s = {(4*N_DIGITS){1'b0}};
        for (int i = 0; i < N_DIGITS; i++) begin
            shadow_flat_s[4*i +: 4] = shadow_r[i];
        end
    end

    // Scan FSM next state and settle counter; an AN change restarts settling
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cap_en_s    = 1'b0;
        if (an_bad_s) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (an_valid_s) begin
                        state_nxt_s = ST_SETTLE;
                        cnt_nxt_s   = 8'd1;
                    end else begin
                        cnt_nxt_s   = 8'd0;
                    end
                end
                ST_SETTLE, ST_CAPTURE, ST_HOLD: begin
                    if (an_chg_s) begin
                        if (an_valid_s) begin
                            state_nxt_s = ST_SETTLE;
                            cnt_nxt_s   = 8'd1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = 8'd0;
                        end
                    end else if (state_r == ST_SETTLE) begin
                        if (cnt_r >= SETTLE_LAST) begin
                            state_nxt_s = ST_CAPTURE;
                        end else begin
                            cnt_nxt_s   = cnt_r + 8'd1;
                        end
                    end else if (state_r == ST_CAPTURE) begin
                        cap_en_s    = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 8'd0;
                end
            endcase
        end
    end

    // FSM state, settle counter and previous-AN registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            an_r          <= 8'hFF;
            an_bad_prev_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            an_r          <= AN;
            an_bad_prev_r <= an_bad_s;
        end
    end

    // Shadow capture, frame assembly and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_r[i] <= 4'h0;
            end
            captured_r    <= NONE_CAPTURED;
            frame_chk_r   <= 1'b0;
            frame_gerr_r  <= 1'b0;
            digits_r      <= {(4*N_DIGITS){1'b0}};
            frame_valid_r <= 1'b0;
            glyph_err_r   <= 1'b0;
            an_err_r      <= 1'b0;
        end else begin
            an_err_r      <= an_bad_s && !an_bad_prev_r;
            frame_chk_r   <= cap_en_s && (an_idx_s == LAST_IDX);
            frame_valid_r <= 1'b0;

            for (int i = 0; i < N_DIGITS; i++) begin
                if (cap_en_s && cap_mask_s[i]) begin
                    shadow_r[i] <= glyph_nib_s;
                end else begin
                    shadow_r[i] <= shadow_r[i];
                end
            end

            if (an_bad_s || frame_chk_r) begin
                captured_r <= NONE_CAPTURED;
            end else if (cap_en_s) begin
                captured_r <= captured_r | cap_mask_s;
            end else begin
                captured_r <= captured_r;
            end

            if (an_bad_s || frame_chk_r) begin
                frame_gerr_r <= 1'b0;
            end else if (cap_en_s && glyph_bad_s) begin
                frame_gerr_r <= 1'b1;
            end else begin
                frame_gerr_r <= frame_gerr_r;
            end

            if (frame_chk_r && frame_good_s) begin
                digits_r      <= shadow_flat_s;
                frame_valid_r <= 1'b1;
                glyph_err_r   <= 1'b0;
            end else if (cap_en_s && glyph_bad_s) begin
                glyph_err_r   <= 1'b1;
            end else begin
                glyph_err_r   <= glyph_err_r;
            end
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [N_DIGITS-1:0] dp_shadow_r;
    logic [N_DIGITS-1:0] dp_r;

    // Decimal-point shadow and output, published together with the digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_shadow_r <= NONE_CAPTURED;
            dp_r        <= NONE_CAPTURED;
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (cap_en_s && cap_mask_s[i]) begin
                    dp_shadow_r[i] <= ~SEG[SEG_DP];
                end else begin
                    dp_shadow_r[i] <= dp_shadow_r[i];
                end
            end
            if (frame_chk_r && frame_good_s) begin
                dp_r <= dp_shadow_r;
            end else begin
                dp_r <= dp_r;
            end
        end
    end

    assign dp = dp_r;
`else
    logic unused_dp_s;
    assign unused_dp_s = SEG[SEG_DP];
    assign dp          = NONE_CAPTURED;
`endif

    assign digits      = digits_r;
    assign frame_valid = frame_valid_r;
    assign glyph_err   = glyph_err_r;
    assign an_err      = an_err_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with N_DIGITS=2, SETTLE_CYCLES=4.
module tb_seg_scan_decoder;

    localparam int ND = 2;

`ifdef SEG_SCAN_DP_EN
    localparam logic [1:0] DP_D1 = 2'b10;
`else
    localparam logic [1:0] DP_D1 = 2'b00;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    SEG = 8'hFF;
    logic [7:0]    AN = 8'hFF;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] dp;
    logic          frame_valid;
    logic          glyph_err;
    logic          an_err;

    int total = 0;
    int bad = 0;
    int fv_cnt = 0;
    int ae_cnt = 0;
    int fv_base = 0;
    int ae_base = 0;

    seg_scan_decoder #(.N_DIGITS(ND), .SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SEG         (SEG),
        .AN          (AN),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .glyph_err   (glyph_err),
        .an_err      (an_err)
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (an_err) ae_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [7:0] an, input logic [7:0] seg, input int n);
        AN  = an;
        SEG = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan2(input logic [7:0] s0, input logic [7:0] s1);
        apply(8'hFE, s0, 8);
        apply(8'hFD, s1, 8);
        apply(8'hFF, 8'hFF, 4);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_gerr", 32'(glyph_err), 32'h0);
        check("rst_anerr", 32'(an_err), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-digit frame "10"
        fv_base = fv_cnt;
        scan2(8'hC0, 8'hF9);
        check("t1_fv", 32'(fv_cnt - fv_base), 32'd1);
        check("t1_digits", 32'(digits), 32'h10);
        check("t1_gerr", 32'(glyph_err), 32'h0);
        check("t1_dp", 32'(dp), 32'h0);

        // Digit 1 held only 3 cycles: no capture, no frame
        fv_base = fv_cnt;
        apply(8'hFE, 8'hC0, 8);
        apply(8'hFD, 8'hA4, 3);
        apply(8'hFF, 8'hFF, 6);
        check("t2_fv", 32'(fv_cnt - fv_base), 32'd0);
        check("t2_digits", 32'(digits), 32'h10);

        // Blank digit 0: glyph error, frame discarded
        fv_base = fv_cnt;
        scan2(8'hFF, 8'hF9);
        check("t3_gerr", 32'(glyph_err), 32'h1);
        check("t3_fv", 32'(fv_cnt - fv_base), 32'd0);
        check("t3_digits", 32'(digits), 32'h10);
        // Clean scan "bA" recovers; error sticky until the frame completes
        fv_base = fv_cnt;
        apply(8'hFE, 8'h88, 8);
        check("t3_gerr_sticky", 32'(glyph_err), 32'h1);
        apply(8'hFD, 8'h83, 8);
        apply(8'hFF, 8'hFF, 4);
        check("t3b_fv", 32'(fv_cnt - fv_base), 32'd1);
        check("t3b_digits", 32'(digits), 32'hBA);
        check("t3b_gerr", 32'(glyph_err), 32'h0);
        check("t3b_dp", 32'(dp), 32'h0);

        // Two anodes low: one an_err pulse, partial frame dropped
        fv_base = fv_cnt;
        ae_base = ae_cnt;
        apply(8'hFE, 8'hC0, 8);
        apply(8'hFC, 8'hC0, 3);
        check("t4_anerr_cnt", 32'(ae_cnt - ae_base), 32'd1);
        check("t4_anerr_low", 32'(an_err), 32'h0);
        apply(8'hFD, 8'hF9, 8);
        apply(8'hFF, 8'hFF, 4);
        check("t4_fv", 32'(fv_cnt - fv_base), 32'd0);
        check("t4_digits", 32'(digits), 32'hBA);
        // Anode index beyond N_DIGITS
        apply(8'hFB, 8'hC0, 3);
        check("t4_anerr_range", 32'(ae_cnt - ae_base), 32'd2);
        apply(8'hFF, 8'hFF, 2);

        // Decimal point on digit 1
        fv_base = fv_cnt;
        scan2(8'hC0, 8'h79);
        check("t5_fv", 32'(fv_cnt - fv_base), 32'd1);
        check("t5_digits", 32'(digits), 32'h10);
        check("t5_dp", 32'(dp), 32'(DP_D1));

        // Reset mid-scan
        apply(8'hFE, 8'hA4, 8);
        AN  = 8'hFD;
        SEG = 8'hB0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_digits", 32'(digits), 32'h0);
        check("t6_dp", 32'(dp), 32'h0);
        check("t6_fv", 32'(frame_valid), 32'h0);
        check("t6_gerr", 32'(glyph_err), 32'h0);
        check("t6_anerr", 32'(an_err), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fv_base = fv_cnt;
        apply(8'hFD, 8'hB0, 8);
        apply(8'hFF, 8'hFF, 4);
        check("t6_partial_fv", 32'(fv_cnt - fv_base), 32'd0);
        check("t6_partial_digits", 32'(digits), 32'h0);
        scan2(8'h99, 8'h92);
        check("t6_full_fv", 32'(fv_cnt - fv_base), 32'd1);
        check("t6_full_digits", 32'(digits), 32'h54);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
